// File: rtl/rs_encoder_line_pack_out_ctrl.sv
// Drains a bank of Reed-Solomon encoder units round-robin and packs each codeword's byte stream into LINE_W-bit lines.
// Latency: a line is presented the cycle after its last byte is accepted; one LINE_OUT cycle minimum per line.
// Backpressure: byte rdy is low while a line is pending or the unit-done handshake is open; the line is held stable until dst rdy.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   encoder_out_byte_val/byte byte stream from the unit selected by out_unit_sel
//   out_encoder_byte_rdy      byte accepted when val && rdy
//   out_unit_sel              unit currently being drained
//   encoder_dst_line_*        packed line (byte 0 at the MSB end), pad byte count, last-line flag, val
//   dst_encoder_line_rdy      destination accepts the line
//   out_ctrl_in_ctrl_done     current unit fully drained
//   in_ctrl_out_ctrl_done     input controller acknowledges done
//   stat_codewords            completed-codeword counter, present only when RS_LINE_PACK_STATS_EN is defined
//
// Parity placement: PARITY_PACK=0 starts parity on a fresh line (last data line padded);
// PARITY_PACK=1 packs parity directly after the data bytes.
module rs_encoder_line_pack_out_ctrl #(
    parameter int NUM_RS_UNITS   = 4,
    parameter int NUM_RS_UNITS_W = (NUM_RS_UNITS > 1) ? $clog2(NUM_RS_UNITS) : 1,
    parameter int LINE_W         = 256,
    parameter int DATA_BYTES     = 223,
    parameter int PARITY_BYTES   = 32,
    parameter int PARITY_PACK    = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          encoder_out_byte_val,
    input  logic [7:0]                    encoder_out_byte,
    output logic                          out_encoder_byte_rdy,
    output logic [NUM_RS_UNITS_W-1:0]     out_unit_sel,
    output logic                          encoder_dst_line_val,
    output logic [LINE_W-1:0]             encoder_dst_line_data,
    output logic [$clog2(LINE_W/8)-1:0]   encoder_dst_line_pad,
    output logic                          encoder_dst_line_last,
    input  logic                          dst_encoder_line_rdy,
    output logic                          out_ctrl_in_ctrl_done,
`ifdef RS_LINE_PACK_STATS_EN
    output logic [31:0]                   stat_codewords,
`endif
    input  logic                          in_ctrl_out_ctrl_done
);

    localparam int BPL    = LINE_W / 8;
    localparam int TOTAL  = DATA_BYTES + PARITY_BYTES;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int FILL_W = $clog2(BPL + 1);
    localparam int PAD_W  = $clog2(BPL);

    localparam logic [CNT_W-1:0]          TOTAL_C   = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0]          DATA_C    = CNT_W'(DATA_BYTES);
    localparam logic [FILL_W-1:0]         BPL_C     = FILL_W'(BPL);
    localparam logic [NUM_RS_UNITS_W-1:0] LAST_UNIT = NUM_RS_UNITS_W'(NUM_RS_UNITS - 1);

    typedef enum logic [1:0] {
        ST_READY     = 2'd0,
        ST_COLLECT   = 2'd1,
        ST_LINE_OUT  = 2'd2,
        ST_UNIT_DONE = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [NUM_RS_UNITS_W-1:0]   unit_sel_q, unit_sel_d;
    logic [CNT_W-1:0]            byte_idx_q, byte_idx_d;
    logic [FILL_W-1:0]           fill_q, fill_d;
    logic [LINE_W-1:0]           line_q, line_d;

    logic [LINE_W-1:0]           line_wr;
    logic [FILL_W-1:0]           fill_inc;
    logic [CNT_W-1:0]            idx_inc;
    logic                        line_full;
    logic                        cw_done;

    // Line buffer with the incoming byte dropped into slot fill_q.
    always_comb begin
        line_wr = line_q;
        for (int i = 0; i < BPL; i++) begin
            if (fill_q == FILL_W'(i)) begin
                line_wr[LINE_W-1-8*i -: 8] = encoder_out_byte;
            end
        end
    end

    assign fill_inc = fill_q + FILL_W'(1);
    assign idx_inc  = byte_idx_q + CNT_W'(1);

    // A line closes when it is full, when the data region ends and parity
    // must start on a fresh line, or when the codeword ends.
    assign line_full = (fill_inc == BPL_C)
                    || ((PARITY_PACK == 0) && (idx_inc == DATA_C))
                    || (idx_inc == TOTAL_C);

    always_comb begin
        state_d               = state_q;
        unit_sel_d            = unit_sel_q;
        byte_idx_d            = byte_idx_q;
        fill_d                = fill_q;
        line_d                = line_q;
        cw_done               = 1'b0;
        out_encoder_byte_rdy  = 1'b0;
        encoder_dst_line_val  = 1'b0;
        encoder_dst_line_data = line_q;
        encoder_dst_line_pad  = '0;
        encoder_dst_line_last = 1'b0;
        out_ctrl_in_ctrl_done = 1'b0;

        case (state_q)
            ST_READY: begin
                out_encoder_byte_rdy = 1'b1;
                unit_sel_d           = '0;
                byte_idx_d           = '0;
                fill_d               = '0;
                line_d               = '0;
                if (encoder_out_byte_val) begin
                    line_d     = line_wr;
                    fill_d     = fill_inc;
                    byte_idx_d = idx_inc;
                    // A one-byte data region with fresh-line parity closes
                    // the line straight away.
                    state_d    = line_full ? ST_LINE_OUT : ST_COLLECT;
                end
            end

            ST_COLLECT: begin
                out_encoder_byte_rdy = 1'b1;
                if (encoder_out_byte_val) begin
                    line_d     = line_wr;
                    fill_d     = fill_inc;
                    byte_idx_d = idx_inc;
                    if (line_full) begin
                        state_d = ST_LINE_OUT;
                    end
                end
            end

            ST_LINE_OUT: begin
                encoder_dst_line_val  = 1'b1;
                encoder_dst_line_pad  = PAD_W'(BPL_C - fill_q);
                encoder_dst_line_last = (byte_idx_q == TOTAL_C);
                if (dst_encoder_line_rdy) begin
                    fill_d  = '0;
                    line_d  = '0;
                    state_d = (byte_idx_q == TOTAL_C) ? ST_UNIT_DONE : ST_COLLECT;
                end
            end

            ST_UNIT_DONE: begin
                out_ctrl_in_ctrl_done = 1'b1;
                if (in_ctrl_out_ctrl_done) begin
                    cw_done    = 1'b1;
                    byte_idx_d = '0;
                    if (unit_sel_q == LAST_UNIT) begin
                        unit_sel_d = '0;
                        state_d    = ST_READY;
                    end else begin
                        unit_sel_d = unit_sel_q + NUM_RS_UNITS_W'(1);
                        state_d    = ST_COLLECT;
                    end
                end
            end

            default: begin
                state_d               = state_t'('x);
                unit_sel_d            = 'x;
                byte_idx_d            = 'x;
                fill_d                = 'x;
                line_d                = 'x;
                cw_done               = 1'bx;
                out_encoder_byte_rdy  = 1'bx;
                encoder_dst_line_val  = 1'bx;
                encoder_dst_line_data = 'x;
                encoder_dst_line_pad  = 'x;
                encoder_dst_line_last = 1'bx;
                out_ctrl_in_ctrl_done = 1'bx;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_READY;
            unit_sel_q <= '0;
            byte_idx_q <= '0;
            fill_q     <= '0;
            line_q     <= '0;
        end else begin
            state_q    <= state_d;
            unit_sel_q <= unit_sel_d;
            byte_idx_q <= byte_idx_d;
            fill_q     <= fill_d;
            line_q     <= line_d;
        end
    end

    assign out_unit_sel = unit_sel_q;

`ifdef RS_LINE_PACK_STATS_EN
    // Completed-codeword count; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_codewords <= '0;
        end else if (cw_done) begin
            stat_codewords <= stat_codewords + 32'd1;
        end
    end
`else
    logic unused_cw_done;
    assign unused_cw_done = cw_done;
`endif

endmodule

// File: tb/tb_rs_encoder_line_pack_out_ctrl.sv
module tb_rs_encoder_line_pack_out_ctrl;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  pad;
        logic        last;
        logic        unit;
    } line_t;

    line_t q_a[$];
    line_t q_b[$];
    line_t q_c[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic rst_bc = 1'b1;

    // DUT A: DATA=16 PARITY=4 fresh-line parity, directed stimulus
    logic        byte_val_a, rdy_a, sel_a, val_a, last_a, dst_rdy_a, done_a, ack_a;
    logic [7:0]  byte_a;
    logic [63:0] data_a;
    logic [2:0]  pad_a;
    // DUT B: DATA=12 PARITY=4 packed parity, free running
    logic        byte_val_b, rdy_b, sel_b, val_b, last_b, done_b, ack_b;
    logic [7:0]  byte_b;
    logic [63:0] data_b;
    logic [2:0]  pad_b;
    // DUT C: DATA=13 PARITY=4 fresh-line parity, free running
    logic        byte_val_c, rdy_c, sel_c, val_c, last_c, done_c, ack_c;
    logic [7:0]  byte_c;
    logic [63:0] data_c;
    logic [2:0]  pad_c;
`ifdef RS_LINE_PACK_STATS_EN
    logic [31:0] stat_a, stat_b, stat_c;
`endif

    int   cnt_a = 0, cnt_b = 0, cnt_c = 0;
    int   tot_b = 0, tot_c = 0;
    logic hs_a, hs_b, hs_c;
    logic auto_ack_a = 1'b0;
    logic src_en_bc  = 1'b0;
    logic [63:0] last_line_a = '0;

    localparam int CW_BC = 6;

    always #5 clk = ~clk;

    rs_encoder_line_pack_out_ctrl #(.NUM_RS_UNITS(2), .LINE_W(64), .DATA_BYTES(16),
        .PARITY_BYTES(4), .PARITY_PACK(0)) dut_a (
        .clk(clk), .rst(rst),
        .encoder_out_byte_val(byte_val_a), .encoder_out_byte(byte_a),
        .out_encoder_byte_rdy(rdy_a), .out_unit_sel(sel_a),
        .encoder_dst_line_val(val_a), .encoder_dst_line_data(data_a),
        .encoder_dst_line_pad(pad_a), .encoder_dst_line_last(last_a),
        .dst_encoder_line_rdy(dst_rdy_a), .out_ctrl_in_ctrl_done(done_a),
`ifdef RS_LINE_PACK_STATS_EN
        .stat_codewords(stat_a),
`endif
        .in_ctrl_out_ctrl_done(ack_a));

    rs_encoder_line_pack_out_ctrl #(.NUM_RS_UNITS(2), .LINE_W(64), .DATA_BYTES(12),
        .PARITY_BYTES(4), .PARITY_PACK(1)) dut_b (
        .clk(clk), .rst(rst_bc),
        .encoder_out_byte_val(byte_val_b), .encoder_out_byte(byte_b),
        .out_encoder_byte_rdy(rdy_b), .out_unit_sel(sel_b),
        .encoder_dst_line_val(val_b), .encoder_dst_line_data(data_b),
        .encoder_dst_line_pad(pad_b), .encoder_dst_line_last(last_b),
        .dst_encoder_line_rdy(1'b1), .out_ctrl_in_ctrl_done(done_b),
`ifdef RS_LINE_PACK_STATS_EN
        .stat_codewords(stat_b),
`endif
        .in_ctrl_out_ctrl_done(ack_b));

    rs_encoder_line_pack_out_ctrl #(.NUM_RS_UNITS(2), .LINE_W(64), .DATA_BYTES(13),
        .PARITY_BYTES(4), .PARITY_PACK(0)) dut_c (
        .clk(clk), .rst(rst_bc),
        .encoder_out_byte_val(byte_val_c), .encoder_out_byte(byte_c),
        .out_encoder_byte_rdy(rdy_c), .out_unit_sel(sel_c),
        .encoder_dst_line_val(val_c), .encoder_dst_line_data(data_c),
        .encoder_dst_line_pad(pad_c), .encoder_dst_line_last(last_c),
        .dst_encoder_line_rdy(1'b1), .out_ctrl_in_ctrl_done(done_c),
`ifdef RS_LINE_PACK_STATS_EN
        .stat_codewords(stat_c),
`endif
        .in_ctrl_out_ctrl_done(ack_c));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected lines of one codeword whose byte k has value k.
    task automatic push_cw(input int which, input int dn, input int pn, input int pack, input logic unit);
        line_t l;
        int    fill;
        int    idx;
        l.data = '0;
        l.pad  = '0;
        l.last = 1'b0;
        l.unit = unit;
        fill   = 0;
        for (int k = 0; k < dn + pn; k++) begin
            l.data[63-8*fill -: 8] = k[7:0];
            fill++;
            idx = k + 1;
            if (fill == 8 || (pack == 0 && idx == dn) || idx == dn + pn) begin
                l.pad  = 3'(8 - fill);
                l.last = (idx == dn + pn);
                case (which)
                    0:       q_a.push_back(l);
                    1:       q_b.push_back(l);
                    default: q_c.push_back(l);
                endcase
                l.data = '0;
                fill   = 0;
            end
        end
    endtask

    task automatic pop_check(input int which, input logic [63:0] d, input logic [2:0] p,
                             input logic l, input logic u);
        line_t e;
        int    sz;
        string nm;
        case (which)
            0:       begin nm = "a"; sz = q_a.size(); end
            1:       begin nm = "b"; sz = q_b.size(); end
            default: begin nm = "c"; sz = q_c.size(); end
        endcase
        chk({nm, "_line_expected"}, 64'(sz != 0), 64'd1);
        if (sz != 0) begin
            case (which)
                0:       e = q_a.pop_front();
                1:       e = q_b.pop_front();
                default: e = q_c.pop_front();
            endcase
            chk({nm, "_line_data"}, d, e.data);
            chk({nm, "_line_pad"},  64'(p), 64'(e.pad));
            chk({nm, "_line_last"}, 64'(l), 64'(e.last));
            chk({nm, "_line_unit"}, 64'(u), 64'(e.unit));
            if (which == 0 && l) last_line_a = d;
        end
    endtask

    // One clock cycle. Called at a negedge after inputs are set; the
    // handshakes that will complete at the coming posedge are committed first.
    task automatic tick();
        hs_a = byte_val_a && rdy_a && !rst;
        hs_b = byte_val_b && rdy_b && !rst_bc;
        hs_c = byte_val_c && rdy_c && !rst_bc;
        if (!rst && val_a === 1'b1 && dst_rdy_a) pop_check(0, data_a, pad_a, last_a, sel_a);
        if (!rst_bc && val_b === 1'b1) pop_check(1, data_b, pad_b, last_b, sel_b);
        if (!rst_bc && val_c === 1'b1) pop_check(2, data_c, pad_c, last_c, sel_c);
        if (auto_ack_a) ack_a = (done_a === 1'b1);
        ack_b = (done_b === 1'b1);
        ack_c = (done_c === 1'b1);
        @(posedge clk);
        #1;
        if (hs_a) begin cnt_a = (cnt_a == 19) ? 0 : cnt_a + 1; end
        if (hs_b) begin cnt_b = (cnt_b == 15) ? 0 : cnt_b + 1; tot_b++; end
        if (hs_c) begin cnt_c = (cnt_c == 16) ? 0 : cnt_c + 1; tot_c++; end
        byte_a     = cnt_a[7:0];
        byte_b     = cnt_b[7:0];
        byte_c     = cnt_c[7:0];
        byte_val_b = src_en_bc && (tot_b < CW_BC * 16);
        byte_val_c = src_en_bc && (tot_c < CW_BC * 17);
        @(negedge clk);
        cyc++;
        if (cyc > 5000) begin
            $display("FAIL cycle_budget: observed %0d cycles, required under 5000", cyc);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    task automatic wait_done_a(input string tag);
        int n = 0;
        while (done_a !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 64'(done_a), 64'd1);
    endtask

    initial begin
        logic [63:0] hold_d;
        logic [2:0]  hold_p;
        logic        hold_l;
        int          n;

        byte_val_a = 1'b0; byte_a = '0; dst_rdy_a = 1'b1; ack_a = 1'b0;
        byte_val_b = 1'b0; byte_b = '0; ack_b = 1'b0;
        byte_val_c = 1'b0; byte_c = '0; ack_c = 1'b0;

        @(negedge clk);
        tick();
        tick();

        // Reset state
        chk("rst_rdy",  64'(rdy_a),  64'd1);
        chk("rst_val",  64'(val_a),  64'd0);
        chk("rst_data", data_a,      64'd0);
        chk("rst_pad",  64'(pad_a),  64'd0);
        chk("rst_last", 64'(last_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_sel",  64'(sel_a),  64'd0);
`ifdef RS_LINE_PACK_STATS_EN
        chk("rst_stat", 64'(stat_a), 64'd0);
`endif

        rst    = 1'b0;
        rst_bc = 1'b0;
        src_en_bc  = 1'b1;
        byte_val_b = 1'b1;
        byte_val_c = 1'b1;
        for (int k = 0; k < CW_BC; k++) begin
            push_cw(1, 12, 4, 1, k[0]);
            push_cw(2, 13, 4, 0, k[0]);
        end

        // Two full units with immediate acknowledge
        auto_ack_a = 1'b1;
        push_cw(0, 16, 4, 0, 1'b0);
        push_cw(0, 16, 4, 0, 1'b1);
        cnt_a = 0; byte_a = 8'h00; byte_val_a = 1'b1;
        wait_done_a("a_done_u0");
        chk("a_tail_line_u0", last_line_a, 64'h10111213_00000000);
        tick();
        chk("a_sel_u1", 64'(sel_a), 64'd1);
        wait_done_a("a_done_u1");
        tick();
        chk("a_sel_wrap", 64'(sel_a), 64'd0);
        chk("a_ready_rdy", 64'(rdy_a), 64'd1);
`ifdef RS_LINE_PACK_STATS_EN
        chk("a_stat_two", 64'(stat_a), 64'd2);
`endif

        // Destination stall during LINE_OUT
        push_cw(0, 16, 4, 0, 1'b0);
        n = 0;
        while (val_a !== 1'b1 && n < 50) begin tick(); n++; end
        chk("a_stall_val", 64'(val_a), 64'd1);
        dst_rdy_a = 1'b0;
        hold_d = data_a; hold_p = pad_a; hold_l = last_a;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_val",  64'(val_a),  64'd1);
            chk("stall_data", data_a,      hold_d);
            chk("stall_pad",  64'(pad_a),  64'(hold_p));
            chk("stall_last", 64'(last_a), 64'(hold_l));
            chk("stall_rdy",  64'(rdy_a),  64'd0);
        end
        dst_rdy_a = 1'b1;
        wait_done_a("a_done_cw2");
        tick();
        auto_ack_a = 1'b0;
        ack_a      = 1'b0;

        // Acknowledge delayed by three cycles
        push_cw(0, 16, 4, 0, 1'b1);
        wait_done_a("a_done_cw3");
        for (int i = 0; i < 3; i++) begin
            chk("dly_done", 64'(done_a), 64'd1);
            chk("dly_sel",  64'(sel_a),  64'd1);
            tick();
        end
        push_cw(0, 16, 4, 0, 1'b0);
        ack_a = 1'b1;
        chk("dly_done_4th", 64'(done_a), 64'd1);
        tick();
        ack_a = 1'b0;
        chk("dly_done_drop", 64'(done_a), 64'd0);
        chk("dly_sel_adv",   64'(sel_a),  64'd0);
        tick();
        chk("dly_sel_once",  64'(sel_a),  64'd0);

        // Acknowledge in the same cycle done is raised
        auto_ack_a = 1'b1;
        wait_done_a("a_done_cw4");
        tick();
        chk("same_done_drop", 64'(done_a), 64'd0);
        chk("same_sel_adv",   64'(sel_a),  64'd1);

        // Reset after five accepted bytes
        n = 0;
        while (cnt_a < 5 && n < 50) begin tick(); n++; end
        chk("mid_bytes", 64'(cnt_a), 64'd5);
        byte_val_a = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_sel",  64'(sel_a),  64'd0);
        chk("mid_rst_val",  64'(val_a),  64'd0);
        chk("mid_rst_rdy",  64'(rdy_a),  64'd1);
        chk("mid_rst_done", 64'(done_a), 64'd0);
`ifdef RS_LINE_PACK_STATS_EN
        chk("mid_rst_stat", 64'(stat_a), 64'd0);
`endif
        rst = 1'b0;
        cnt_a = 0; byte_a = 8'h00;
        tick();
        tick();
        chk("post_rst_val", 64'(val_a), 64'd0);
        last_line_a = '0;
        push_cw(0, 16, 4, 0, 1'b0);
        byte_val_a = 1'b1;
        wait_done_a("a_done_fresh");
        chk("a_tail_line_fresh", last_line_a, 64'h10111213_00000000);
        tick();

        n = 0;
        while ((q_b.size() != 0 || q_c.size() != 0) && n < 400) begin tick(); n++; end
        chk("a_queue_empty", 64'(q_a.size()), 64'd0);
        chk("b_queue_empty", 64'(q_b.size()), 64'd0);
        chk("c_queue_empty", 64'(q_c.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
